// File: rtl/sd_crc_lanes_if.sv
// Handshake/data bundle between the SD shifters and the multi-lane CRC engine.
// master drives the payload side and slave is the CRC engine.
interface sd_crc_lanes_if #(
    parameter int LANES = 1,
    parameter int CRC_W = 7
);
    logic                   clear;
    logic                   bit_en;
    logic [LANES-1:0]       bit_in;
    logic                   shift_start;
    logic                   chk_start;
    logic [LANES*CRC_W-1:0] crc_out;
    logic [LANES-1:0]       ser_out;
    logic                   ser_valid;
    logic                   busy;
    logic                   done;
    logic [LANES-1:0]       crc_err;

    modport master (
        output clear,
        output bit_en,
        output bit_in,
        output shift_start,
        output chk_start,
        input  crc_out,
        input  ser_out,
        input  ser_valid,
        input  busy,
        input  done,
        input  crc_err
    );

    modport slave (
        input  clear,
        input  bit_en,
        input  bit_in,
        input  shift_start,
        input  chk_start,
        output crc_out,
        output ser_out,
        output ser_valid,
        output busy,
        output done,
        output crc_err
    );
endinterface

// File: rtl/sd_crc_lanes.sv
// Multi-lane MSB-first CRC engine with serialiser for the SD host datapath.
// Define SD_CRC_CHECK_EN to build the receive-side CRC checker (CHECK state).
module sd_crc_lanes #(
    parameter int          CRC_W = 7,
    parameter logic [31:0] POLY  = 7'h09,
    parameter int          LANES = 1
) (
    input logic          clk,
    input logic          rst,
    sd_crc_lanes_if.slave bus
);
    localparam int CNT_W = $clog2(CRC_W);
    localparam logic [CRC_W-1:0] POLY_M  = POLY[CRC_W-1:0];
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t state;
    state_t state_d;

    logic [LANES-1:0][CRC_W-1:0] crc;
    logic [LANES-1:0][CRC_W-1:0] crc_sh;
    logic [LANES-1:0][CRC_W-1:0] crc_fb;
    logic [LANES-1:0]            msb;
    logic [LANES-1:0]            inv;
    logic [CNT_W-1:0]            cnt;
    logic                        last;
    logic                        done_q;
    logic                        ser_v;

    assign last = (cnt == '0);

    // Per-lane LFSR step; inv doubles as the receive mismatch flag.
    always_comb begin
        msb    = '0;
        inv    = '0;
        crc_sh = '0;
        crc_fb = '0;
        for (int n = 0; n < LANES; n++) begin
            msb[n]    = crc[n][CRC_W-1];
            inv[n]    = bus.bit_in[n] ^ crc[n][CRC_W-1];
            crc_sh[n] = {crc[n][CRC_W-2:0], 1'b0};
            crc_fb[n] = crc_sh[n] ^ (inv[n] ? POLY_M : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.shift_start) begin
                        state_d = SHIFT;
`ifdef SD_CRC_CHECK_EN
                    end else if (bus.chk_start) begin
                        state_d = CHECK;
`endif
                    end
                end
                SHIFT: begin
                    if (last) begin
                        state_d = IDLE;
                    end
                end
`ifdef SD_CRC_CHECK_EN
                CHECK: begin
                    if (bus.bit_en && last) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef SD_CRC_CHECK_EN
    logic [LANES-1:0] err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            crc    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef SD_CRC_CHECK_EN
            err    <= '0;
`endif
        end else if (bus.clear) begin
            crc    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef SD_CRC_CHECK_EN
            err    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.bit_en) begin
                        crc <= crc_fb;
                    end
`ifdef SD_CRC_CHECK_EN
                    if (bus.shift_start || bus.chk_start) begin
`else
                    if (bus.shift_start) begin
`endif
                        cnt <= CNT_TOP;
                    end
                end
                // Zero-fill shifting leaves crc cleared after CRC_W cycles.
                SHIFT: begin
                    crc <= crc_sh;
                    cnt <= last ? '0 : cnt - 1'b1;
                    if (last) begin
                        done_q <= 1'b1;
                    end
                end
`ifdef SD_CRC_CHECK_EN
                CHECK: begin
                    if (bus.bit_en) begin
                        crc <= crc_sh;
                        err <= err | inv;
                        cnt <= last ? '0 : cnt - 1'b1;
                        if (last) begin
                            done_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    crc <= crc;
                end
            endcase
        end
    end

    always_comb begin
        ser_v         = (state == SHIFT);
        bus.ser_valid = ser_v;
        bus.busy      = (state != IDLE);
        bus.ser_out   = ser_v ? msb : '0;
    end

    assign bus.crc_out = crc;
    assign bus.done    = done_q;

`ifdef SD_CRC_CHECK_EN
    assign bus.crc_err = err;
`else
    logic unused_chk;
    assign unused_chk  = bus.chk_start;
    assign bus.crc_err = '0;
`endif
endmodule
